// File: rtl/weighted_round_robin_arbiter.sv
// weighted_round_robin_arbiter
// Weighted round-robin arbiter: each channel may hold the grant for up to its
// programmed weight in consecutive cycles before priority rotates onward.
// Grant is combinational from the requests and the registered burst state.
// Optional feature: define WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN to add the
// `lock` input, which lets the current owner keep the grant indefinitely.
module weighted_round_robin_arbiter #(
    parameter int SIZE         = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [SIZE-1:0]              requests,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    input  logic                         lock,
`endif
    output logic [SIZE-1:0]              grant,
    output logic                         grant_valid,
    output logic [INDEX_WIDTH-1:0]       grant_index
);

    logic [INDEX_WIDTH-1:0]  r_owner;
    logic                    r_ownerValid;
    logic [WEIGHT_WIDTH-1:0] r_count;

    logic [WEIGHT_WIDTH-1:0] w_weightArr [SIZE];
    logic [WEIGHT_WIDTH-1:0] w_ownerWeight;
    logic [WEIGHT_WIDTH-1:0] w_effWeight;
    logic                    w_continue;
    logic                    w_lockHold;
    logic                    w_keepOwner;
    int                      w_start;
    logic                    w_hiFound;
    logic [INDEX_WIDTH-1:0]  w_hiIdx;
    logic [INDEX_WIDTH-1:0]  w_loIdx;
    logic [INDEX_WIDTH-1:0]  w_searchIdx;
    logic [INDEX_WIDTH-1:0]  w_grantIdx;
    logic                    w_grantValid;

    // Unpack the flat weight bus into one weight per channel
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            w_weightArr[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

    // A zero weight still earns one grant per turn, so a channel is never starved
    assign w_ownerWeight = w_weightArr[r_owner];
    assign w_effWeight   = (w_ownerWeight == '0) ? WEIGHT_WIDTH'(1) : w_ownerWeight;
    assign w_continue    = r_ownerValid && requests[r_owner] && (r_count < w_effWeight);

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    assign w_lockHold = lock && r_ownerValid && requests[r_owner];
`else
    assign w_lockHold = 1'b0;
`endif

    assign w_keepOwner = w_continue || w_lockHold;

    // Round-robin search: the lowest requester at or above the start point wins,
    // otherwise wrap around to the lowest requester overall (which may be the owner)
    always_comb begin
        w_start   = 0;
        w_hiFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        if (r_ownerValid && (int'(r_owner) < SIZE - 1)) begin
            w_start = int'(r_owner) + 1;
        end
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (requests[i]) begin
                w_loIdx = INDEX_WIDTH'(i);
                if (i >= w_start) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = INDEX_WIDTH'(i);
                end
            end
        end
        w_searchIdx = w_hiFound ? w_hiIdx : w_loIdx;
    end

    assign w_grantValid = resetn && (|requests);
    assign w_grantIdx   = w_keepOwner ? r_owner : w_searchIdx;

    // Decode the winner to one-hot; everything is forced low while in reset
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            grant[i] = w_grantValid && (w_grantIdx == INDEX_WIDTH'(i));
        end
    end

    assign grant_valid = w_grantValid;
    assign grant_index = w_grantValid ? w_grantIdx : '0;

    // Burst bookkeeping: extend the current burst, hold it under lock, or start a new one
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_owner      <= '0;
            r_ownerValid <= 1'b0;
            r_count      <= '0;
        end else if (w_grantValid) begin
            if (w_lockHold) begin
                r_count <= r_count;
            end else if (w_continue) begin
                r_count <= r_count + WEIGHT_WIDTH'(1);
            end else begin
                r_owner      <= w_searchIdx;
                r_ownerValid <= 1'b1;
                r_count      <= WEIGHT_WIDTH'(1);
            end
        end
    end

endmodule
